// File: rtl/sub_bytes_iter.sv
// Iterative AES byte substitution: LANES S-box lookups per cycle over a 128-bit block,
// with per-byte pass-through mask and forward/inverse selection latched at acceptance.
module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic [15:0]  in_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned GROUPS = 16 / LANES;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 sits in the most significant byte of each table.
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic inv, input logic [7:0] b);
    int unsigned pos;
    pos = 8 * (255 - int'(b));
    return inv ? INV[pos +: 8] : FWD[pos +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [127:0]    data_q, data_d;
  logic            inv_q, inv_d;
  logic [15:0]     mask_q, mask_d;
  int unsigned     bi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    data_d  = data_q;
    inv_d   = inv_q;
    mask_d  = mask_q;
    bi      = 0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          inv_d   = in_inv;
          mask_d  = in_mask;
          grp_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Each lane owns one byte of the current group; masked-off bytes keep their value.
        for (int unsigned l = 0; l < LANES; l++) begin
          bi = int'(grp_q) * LANES + l;
          if (mask_q[bi]) begin
            data_d[8*bi +: 8] = sbox(inv_q, data_q[8*bi +: 8]);
          end
        end
        if (grp_q == GW'(GROUPS - 1)) begin
          grp_d   = '0;
          state_d = DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule
